// File: rtl/gfx_pkg.sv
// gfx_pkg: shared definitions for the rectangle engine.
//   - opcode constants (fill / blit / keyed blit; code 3 behaves as fill)
//   - FSM state encoding
//   - default screen geometry and the clog2-derived coordinate widths
package gfx_pkg;

  localparam logic [1:0] OP_FILL  = 2'd0;
  localparam logic [1:0] OP_BLIT  = 2'd1;
  localparam logic [1:0] OP_KEYED = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_X_W      = $clog2(DEF_SCREEN_W);
  localparam int DEF_Y_W      = $clog2(DEF_SCREEN_H);
  localparam int DEF_A_W      = $clog2(DEF_SCREEN_W * DEF_SCREEN_H);

  // Both blit flavours read the sprite ROM; everything else is a fill.
  function automatic logic is_blit_op(input logic [1:0] op);
    return (op == OP_BLIT) || (op == OP_KEYED);
  endfunction

endpackage

// File: rtl/gfx_delay_line.sv
// gfx_delay_line: fixed-depth register delay line for pixel payloads.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   din      : payload entering this clock ({valid, x, y} in the blitter)
//   dout     : payload that entered DEPTH clocks ago
module gfx_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[DEPTH-1];

endmodule

// File: rtl/gfx_blitter.sv
// gfx_blitter: rectangle engine writing one pixel per clock into VRAM.
//   clk, rst          : clock, synchronous active-high reset
//   start, opcode     : command request (sampled in IDLE only) and mode
//   tl_x/tl_y/br_x/br_y: inclusive rectangle corners
//   arg               : fill colour, or transparent key for keyed blit
//   rom_base          : first sprite ROM address
//   rom_addr/rom_data : sprite ROM port, data returns ROM_LAT clocks later
//   vram_we/addr/data : VRAM write port (addr = y*SCREEN_W + x)
//   busy, done        : busy while running/draining, one-clock done pulse
//
// Timing: the pixel being visited in RUN sits on the delay-line input
// while rom_addr holds its sprite address. After ROM_LAT clocks the
// delay-line output lines up with rom_data, and one more register forms
// the VRAM write. Fill takes the same path so latency never depends on mode.
module gfx_blitter import gfx_pkg::*; #(
  parameter  int SCREEN_W = DEF_SCREEN_W,
  parameter  int SCREEN_H = DEF_SCREEN_H,
  parameter  int COLOR_W  = 12,
  parameter  int ROM_AW   = 18,
  parameter  int ROM_LAT  = 1,
  localparam int X_W      = $clog2(SCREEN_W),
  localparam int Y_W      = $clog2(SCREEN_H),
  localparam int A_W      = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         opcode,
  input  logic [X_W-1:0]     tl_x,
  input  logic [Y_W-1:0]     tl_y,
  input  logic [X_W-1:0]     br_x,
  input  logic [Y_W-1:0]     br_y,
  input  logic [COLOR_W-1:0] arg,
  input  logic [ROM_AW-1:0]  rom_base,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               vram_we,
  output logic [A_W-1:0]     vram_addr,
  output logic [COLOR_W-1:0] vram_data,
  output logic               busy,
  output logic               done
);

  // Drain covers the delay line plus the VRAM output register, so done
  // fires the clock after the final write has been presented.
  localparam int DRAIN_LEN = ROM_LAT + 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);
  localparam int PW        = 1 + X_W + Y_W;

  state_t             state;
  logic [1:0]         op_q;
  logic [COLOR_W-1:0] arg_q;
  logic [X_W-1:0]     tl_x_q, br_x_q, cur_x;
  logic [Y_W-1:0]     br_y_q, cur_y;
  logic [DW-1:0]      drain_cnt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      op_q      <= OP_FILL;
      arg_q     <= '0;
      tl_x_q    <= '0;
      br_x_q    <= '0;
      br_y_q    <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= opcode;
            arg_q  <= arg;
            tl_x_q <= tl_x;
            br_x_q <= br_x;
            br_y_q <= br_y;
            cur_x  <= tl_x;
            cur_y  <= tl_y;
            if (tl_x > br_x || tl_y > br_y) begin
              // Empty rectangle: straight to completion, ROM untouched.
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
              if (is_blit_op(opcode)) rom_addr <= rom_base;
            end
          end
        end
        S_RUN: begin
          // Sprite pointer advances for every visited pixel, clipped or not.
          if (is_blit_op(op_q)) rom_addr <= rom_addr + ROM_AW'(1);
          // Compare before increment so an all-ones corner never wraps.
          if (cur_x == br_x_q) begin
            cur_x <= tl_x_q;
            if (cur_y == br_y_q) begin
              state     <= S_DRAIN;
              drain_cnt <= DW'(DRAIN_LEN - 1);
            end else begin
              cur_y <= cur_y + Y_W'(1);
            end
          end else begin
            cur_x <= cur_x + X_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------- pixel pipeline
  logic [PW-1:0]  dl_in, dl_out;
  logic           dl_vld;
  logic [X_W-1:0] dl_x;
  logic [Y_W-1:0] dl_y;
  logic           pix_wr;

  assign dl_in = {state == S_RUN, cur_x, cur_y};
  assign {dl_vld, dl_x, dl_y} = dl_out;

  gfx_delay_line #(
    .DEPTH (ROM_LAT),
    .W     (PW)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  // Drop off-screen pixels and, in keyed mode, pixels matching the key.
  assign pix_wr = dl_vld
               && (int'(dl_x) < SCREEN_W)
               && (int'(dl_y) < SCREEN_H)
               && !(op_q == OP_KEYED && rom_data == arg_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= pix_wr;
      // Address/data only load for real writes, so the address multiply
      // only ever sees on-screen coordinates.
      if (pix_wr) begin
        vram_addr <= A_W'(dl_y) * A_W'(SCREEN_W) + A_W'(dl_x);
        vram_data <= is_blit_op(op_q) ? rom_data : arg_q;
      end
    end
  end

endmodule

// File: tb/tb_gfx_blitter.sv
`timescale 1ns/1ps
module tb_gfx_blitter;

  localparam int SW = 640;
  localparam int SH = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  opcode = '0;
  logic [9:0]  tl_x = '0, br_x = '0;
  logic [8:0]  tl_y = '0, br_y = '0;
  logic [11:0] arg = '0;
  logic [17:0] rom_base = '0;

  // index 0: ROM_LAT=1 instance, index 1: ROM_LAT=2 instance
  logic [17:0] rom_addr_o  [2];
  logic [11:0] rom_data_i  [2];
  logic        vram_we_o   [2];
  logic [18:0] vram_addr_o [2];
  logic [11:0] vram_data_o [2];
  logic        busy_o      [2];
  logic        done_o      [2];

  logic [11:0] rq1, rq2a, rq2b;

  int vectors = 0;
  int miscompares = 0;
  int exp_rom = 0;

  typedef struct { int dut; int addr; int data; int t; } wr_t;
  typedef struct { int addr; int data; int k; } exp_t;
  wr_t  got[$];
  exp_t expq[$];

  always #5 clk = ~clk;

  // Sprite ROM: content is the low 12 address bits, returned ROM_LAT clocks later.
  always @(posedge clk) begin
    rq1  <= rom_addr_o[0][11:0];
    rq2a <= rom_addr_o[1][11:0];
    rq2b <= rq2a;
  end
  assign rom_data_i[0] = rq1;
  assign rom_data_i[1] = rq2b;

  gfx_blitter #(.SCREEN_W(SW), .SCREEN_H(SH), .COLOR_W(12), .ROM_AW(18), .ROM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .tl_x(tl_x), .tl_y(tl_y), .br_x(br_x), .br_y(br_y),
    .arg(arg), .rom_base(rom_base),
    .rom_addr(rom_addr_o[0]), .rom_data(rom_data_i[0]),
    .vram_we(vram_we_o[0]), .vram_addr(vram_addr_o[0]), .vram_data(vram_data_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));

  gfx_blitter #(.SCREEN_W(SW), .SCREEN_H(SH), .COLOR_W(12), .ROM_AW(18), .ROM_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .tl_x(tl_x), .tl_y(tl_y), .br_x(br_x), .br_y(br_y),
    .arg(arg), .rom_base(rom_base),
    .rom_addr(rom_addr_o[1]), .rom_data(rom_data_i[1]),
    .vram_we(vram_we_o[1]), .vram_addr(vram_addr_o[1]), .vram_data(vram_data_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command, watch both instances until they finish, then compare
  // every write, its cycle, done timing, busy length and final ROM pointer
  // with a raster-walk model. rs_a/rs_b: cycles at which a stray start is raised.
  task automatic run_cmd(input string name, input int op, input int tlx, input int tly,
                         input int brx, input int bry, input int av, input int base,
                         input int rs_a = -1, input int rs_b = -1);
    int  n = 0;
    bit  empty;
    int  done_t[2], done_n[2], busy_n[2], busy_dn[2];
    int  t = 0;
    bit  fin = 0;
    expq.delete();
    got.delete();
    empty = (tlx > brx) || (tly > bry);
    if (!empty) begin
      for (int y = tly; y <= bry; y++) begin
        for (int x = tlx; x <= brx; x++) begin
          int ptr, rv, dv;
          bit wr;
          ptr = (base + n) % (1 << 18);
          rv  = ptr % 4096;
          dv  = (op == 1 || op == 2) ? rv : av;
          wr  = (x < SW) && (y < SH) && !(op == 2 && rv == av);
          if (wr) expq.push_back('{y * SW + x, dv, n});
          n++;
        end
      end
      if (op == 1 || op == 2) exp_rom = (base + n) % (1 << 18);
    end
    for (int d = 0; d < 2; d++) begin
      done_t[d] = -1; done_n[d] = 0; busy_n[d] = 0; busy_dn[d] = 0;
    end
    @(negedge clk);
    opcode = 2'(op); tl_x = 10'(tlx); tl_y = 9'(tly); br_x = 10'(brx); br_y = 9'(bry);
    arg = 12'(av); rom_base = 18'(base); start = 1'b1;
    while (!fin && t < 1000) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (vram_we_o[d]) got.push_back('{d, int'(vram_addr_o[d]), int'(vram_data_o[d]), t});
        if (done_o[d]) begin
          done_n[d]++;
          if (done_t[d] < 0) done_t[d] = t;
          if (busy_o[d]) busy_dn[d]++;
        end
        if (busy_o[d]) busy_n[d]++;
      end
      start = (t == rs_a || t == rs_b);
      if (done_t[0] >= 0 && done_t[1] >= 0 && t >= done_t[0] + 4 && t >= done_t[1] + 4) fin = 1;
      t++;
    end
    start = 1'b0;
    if (!fin) chk({name, " timeout"}, 0, 1);
    for (int d = 0; d < 2; d++) begin
      int lat = d + 1;
      int j = 0;
      string p = $sformatf("%s lat%0d", name, lat);
      foreach (got[i]) begin
        if (got[i].dut == d) begin
          if (j < expq.size()) begin
            chk({p, " addr"},  got[i].addr, expq[j].addr);
            chk({p, " data"},  got[i].data, expq[j].data);
            chk({p, " cycle"}, got[i].t, 1 + lat + expq[j].k);
          end
          j++;
        end
      end
      chk({p, " writes"},       j, expq.size());
      chk({p, " done_cycle"},   done_t[d], empty ? 0 : n + lat + 1);
      chk({p, " done_count"},   done_n[d], 1);
      chk({p, " busy_cycles"},  busy_n[d], empty ? 0 : n + lat + 1);
      chk({p, " busy_in_done"}, busy_dn[d], 0);
      chk({p, " rom_addr"},     int'(rom_addr_o[d]), exp_rom);
    end
  endtask

  initial begin
    int nw;
    // ---- reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset vram_we",   int'(vram_we_o[d]), 0);
      chk("reset busy",      int'(busy_o[d]), 0);
      chk("reset done",      int'(done_o[d]), 0);
      chk("reset rom_addr",  int'(rom_addr_o[d]), 0);
      chk("reset vram_addr", int'(vram_addr_o[d]), 0);
      chk("reset vram_data", int'(vram_data_o[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // ---- directed cases
    run_cmd("fill2x2", 0, 0, 0, 1, 1, 'hF00, 0);
    run_cmd("blit",    1, 10, 5, 12, 5, 0, 'h100);
    run_cmd("keyed",   2, 10, 5, 12, 5, 'h101, 'h100);
    run_cmd("clip",    0, 638, 479, 641, 479, 'h0F0, 0);
    run_cmd("empty",   1, 20, 0, 19, 0, 'h123, 'h3000);
    run_cmd("allones", 1, 1021, 510, 1023, 511, 0, 'h3FFFE);
    run_cmd("opc3",    3, 100, 100, 102, 100, 'hABC, 'h200);
    // stray starts: mid-run, and in the ROM_LAT=1 instance's DONE cycle
    run_cmd("ignore",  0, 0, 20, 99, 20, 'h555, 0, 5, 1 + 100 + 1);

    // ---- reset in the middle of a fill
    @(negedge clk);
    opcode = 2'd0; tl_x = 10'd0; tl_y = 9'd30; br_x = 10'd99; br_y = 9'd30;
    arg = 12'h777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("midrst vram_we", int'(vram_we_o[d]), 0);
      chk("midrst busy",    int'(busy_o[d]), 0);
    end
    rst = 1'b0;
    exp_rom = 0;
    nw = 0;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (vram_we_o[d] || busy_o[d] || done_o[d]) nw++;
    end
    chk("midrst quiet", nw, 0);
    run_cmd("after_rst", 1, 3, 2, 6, 3, 0, 'h40);

    // ---- randomized commands
    for (int it = 0; it < 12; it++) begin
      int op, tlx, tly, brx, bry, av, base, w, h;
      op   = $urandom_range(0, 3);
      tlx  = $urandom_range(0, 1023);
      tly  = $urandom_range(0, 511);
      w    = $urandom_range(1, 5);
      h    = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) begin tlx = $urandom_range(0, 630); tly = $urandom_range(0, 470); end
      brx  = (tlx + w - 1 > 1023) ? 1023 : tlx + w - 1;
      bry  = (tly + h - 1 > 511) ? 511 : tly + h - 1;
      if ($urandom_range(0, 7) == 0 && tlx > 0) brx = tlx - 1;
      base = ($urandom_range(0, 3) == 0) ? (1 << 18) - 2 : $urandom_range(0, (1 << 18) - 1);
      av   = $urandom_range(0, 4095);
      if (op == 2 && $urandom_range(0, 1) == 1) av = (base + $urandom_range(0, 3)) % 4096;
      run_cmd($sformatf("rand%0d", it), op, tlx, tly, brx, bry, av, base);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
